// File: rtl/md5_pkg.sv
// MD5 constants, round functions and message-index schedule shared by the
// iterative compression core and its per-step datapath.
package md5_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  localparam logic [31:0]  IV_A = 32'h67452301;
  localparam logic [31:0]  IV_B = 32'hefcdab89;
  localparam logic [31:0]  IV_C = 32'h98badcfe;
  localparam logic [31:0]  IV_D = 32'h10325476;
  localparam logic [127:0] IV   = {IV_D, IV_C, IV_B, IV_A};

  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amount depends only on the round and the step position mod 4.
  function automatic logic [4:0] s_amt(input logic [5:0] i);
    case ({i[5:4], i[1:0]})
      4'h0: s_amt = 5'd7;   4'h1: s_amt = 5'd12;  4'h2: s_amt = 5'd17;  4'h3: s_amt = 5'd22;
      4'h4: s_amt = 5'd5;   4'h5: s_amt = 5'd9;   4'h6: s_amt = 5'd14;  4'h7: s_amt = 5'd20;
      4'h8: s_amt = 5'd4;   4'h9: s_amt = 5'd11;  4'ha: s_amt = 5'd16;  4'hb: s_amt = 5'd23;
      4'hc: s_amt = 5'd6;   4'hd: s_amt = 5'd10;  4'he: s_amt = 5'd15;  default: s_amt = 5'd21;
    endcase
  endfunction

  function automatic logic [3:0] g_idx(input logic [5:0] i);
    logic [3:0] ii;
    ii = i[3:0];
    case (i[5:4])
      2'd0:    g_idx = ii;
      2'd1:    g_idx = ii * 4'd5 + 4'd1;
      2'd2:    g_idx = ii * 4'd3 + 4'd5;
      default: g_idx = ii * 4'd7;
    endcase
  endfunction

  function automatic logic [31:0] fn_f(input logic [31:0] b, c, d);
    fn_f = (b & c) | (~b & d);
  endfunction
  function automatic logic [31:0] fn_g(input logic [31:0] b, c, d);
    fn_g = (b & d) | (c & ~d);
  endfunction
  function automatic logic [31:0] fn_h(input logic [31:0] b, c, d);
    fn_h = b ^ c ^ d;
  endfunction
  function automatic logic [31:0] fn_i(input logic [31:0] b, c, d);
    fn_i = c ^ (b | ~d);
  endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step; the step index selects round function,
// message word, rotate amount and constant.
module md5_step
  import md5_pkg::*;
(
  input  logic [5:0]   idx,
  input  logic [511:0] blk,
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out
);

  logic [31:0] f_val;
  logic [31:0] m_word;
  logic [31:0] sum;
  logic [63:0] dbl;

  always_comb begin
    case (idx[5:4])
      2'd0:    f_val = fn_f(b_in, c_in, d_in);
      2'd1:    f_val = fn_g(b_in, c_in, d_in);
      2'd2:    f_val = fn_h(b_in, c_in, d_in);
      default: f_val = fn_i(b_in, c_in, d_in);
    endcase
    m_word = blk[{g_idx(idx), 5'b0} +: 32];
    sum    = a_in + f_val + K[idx] + m_word;
    // Rotate-left: shift the doubled word and keep the upper half.
    dbl    = {sum, sum} << s_amt(idx);
    a_out  = d_in;
    b_out  = b_in + dbl[63:32];
    c_out  = b_in;
    d_out  = c_in;
  end

endmodule

// File: rtl/md5_compress_iter.sv
// Iterative MD5 compression: UNROLL steps per clock, block period 64/UNROLL+2;
// in_ready is low for the whole block, out_valid is an unthrottled one-cycle pulse.
module md5_compress_iter
  import md5_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  input  logic         in_last,
  output logic         out_valid,
  output logic [127:0] out_digest,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
    $error("md5_compress_iter: UNROLL must be 1, 2, 4, 8 or 16");
  end

  localparam logic [5:0] STEP_INC = 6'(UNROLL);
  localparam logic [5:0] LAST_IDX = 6'(64 - UNROLL);

  state_e       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [511:0] blk_q, blk_d;
  logic         last_q, last_d;
  logic [31:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [127:0] h_q, h_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] out_digest_q, out_digest_d;
  logic [127:0] ff_sum;

  logic [31:0] wa [UNROLL+1];
  logic [31:0] wb [UNROLL+1];
  logic [31:0] wc [UNROLL+1];
  logic [31:0] wd [UNROLL+1];

  assign wa[0] = a_q;
  assign wb[0] = b_q;
  assign wc[0] = c_q;
  assign wd[0] = d_q;

  for (genvar u = 0; u < UNROLL; u++) begin : g_step
    md5_step u_step (
      .idx   (cnt_q + 6'(u)),
      .blk   (blk_q),
      .a_in  (wa[u]),   .b_in  (wb[u]),   .c_in  (wc[u]),   .d_in  (wd[u]),
      .a_out (wa[u+1]), .b_out (wb[u+1]), .c_out (wc[u+1]), .d_out (wd[u+1])
    );
  end

  assign ff_sum = {h_q[127:96] + d_q, h_q[95:64] + c_q, h_q[63:32] + b_q, h_q[31:0] + a_q};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    blk_d        = blk_q;
    last_d       = last_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    d_d          = d_q;
    h_d          = h_q;
    out_valid_d  = 1'b0;
    out_digest_d = out_digest_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          blk_d  = in_block;
          last_d = in_last;
          cnt_d  = '0;
          {d_d, c_d, b_d, a_d} = in_first ? IV : h_q;
          if (in_first) h_d = IV;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = wa[UNROLL];
        b_d   = wb[UNROLL];
        c_d   = wc[UNROLL];
        d_d   = wd[UNROLL];
        cnt_d = cnt_q + STEP_INC;
        if (cnt_q == LAST_IDX) state_d = FIN;
      end
      FIN: begin
        h_d = ff_sum;
        if (last_q) begin
          out_digest_d = ff_sum;
          out_valid_d  = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      blk_q        <= '0;
      last_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      d_q          <= '0;
      h_q          <= IV;
      out_valid_q  <= 1'b0;
      out_digest_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      blk_q        <= blk_d;
      last_q       <= last_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      d_q          <= d_d;
      h_q          <= h_d;
      out_valid_q  <= out_valid_d;
      out_digest_q <= out_digest_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = out_valid_q;
  assign out_digest = out_digest_q;

endmodule

// File: tb/tb_md5_compress_iter.sv
// Directed bench for md5_compress_iter: scoreboard of expected digests and due
// cycles, plus one extra instance per wider UNROLL running "abc".
module tb_md5_compress_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_block;
  logic         in_first;
  logic         in_last;
  logic         out_valid;
  logic [127:0] out_digest;
  logic         busy;

  always #5 clk = ~clk;

  md5_compress_iter #(.UNROLL(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .in_first   (in_first),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_digest (out_digest),
    .busy       (busy)
  );

  logic         xv [4];
  logic         xr [4];
  logic         xo [4];
  logic         xb [4];
  logic [127:0] xd [4];

  for (genvar j = 0; j < 4; j++) begin : g_wide
    md5_compress_iter #(.UNROLL(2 << j)) u_wide (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (xv[j]),
      .in_ready   (xr[j]),
      .in_block   (in_block),
      .in_first   (1'b1),
      .in_last    (1'b1),
      .out_valid  (xo[j]),
      .out_digest (xd[j]),
      .busy       (xb[j])
    );
  end

  localparam logic [127:0] EMPTY_DIG = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
  localparam logic [127:0] ABC_DIG   = 128'h727fe128_7d3f96d6_b04fd23c_98500190;
  localparam logic [127:0] RFC_DIG   = 128'h7ab60721_2eda49ac_55c9e32b_a2f4ed57;
  localparam int           LAT1      = 65;  // accept edge to out_valid-visible edge at UNROLL=1

  typedef struct {
    logic [127:0] dig;
    int           due;
  } exp_t;

  exp_t sb [$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_acc = 0;

  logic [511:0] empty_blk;
  logic [511:0] abc_blk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rfc_byte(input int n);
    if (n < 80)        rfc_byte = 8'(48 + ((n + 1) % 10));
    else if (n == 80)  rfc_byte = 8'h80;
    else if (n == 120) rfc_byte = 8'h80;
    else if (n == 121) rfc_byte = 8'h02;
    else               rfc_byte = 8'h00;
  endfunction

  function automatic logic [511:0] rfc_blk(input int k);
    logic [511:0] r;
    r = '0;
    for (int b = 0; b < 64; b++) r[8*b +: 8] = rfc_byte(64*k + b);
    return r;
  endfunction

  // Scoreboard consumer: every out_valid must match the oldest expectation,
  // both in value and in the cycle it appears.
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 128'(out_valid), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("digest", out_digest, e.dig);
        check("out_valid_cycle", 128'(cyc), 128'(e.due));
      end
    end
  end

  // Called at #1 after an edge; returns at #1 after the accept edge.
  task automatic send(input logic [511:0] blk, input logic first, input logic last,
                      input bit keep, input bit push, input logic [127:0] exp);
    int n;
    in_valid = 1'b1;
    in_block = blk;
    in_first = first;
    in_last  = last;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      check("accept_timeout", 128'(0), 128'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    last_acc = cyc;
    if (push && last) sb.push_back('{dig: exp, due: last_acc + LAT1});
    if (!keep) in_valid = 1'b0;
    check("in_ready_after_accept", 128'(in_ready), 128'(0));
    check("busy_after_accept", 128'(busy), 128'(1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || in_ready !== 1'b1) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("idle_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    int a1;
    empty_blk         = '0;
    empty_blk[7:0]    = 8'h80;
    abc_blk           = '0;
    abc_blk[31:0]     = 32'h80636261;
    abc_blk[455:448]  = 8'h18;

    rst = 1'b1; in_valid = 1'b0; in_block = '0; in_first = 1'b0; in_last = 1'b0;
    for (int j = 0; j < 4; j++) xv[j] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_digest", out_digest, 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-block empty string and "abc".
    send(empty_blk, 1'b1, 1'b1, 1'b0, 1'b1, EMPTY_DIG);
    wait_idle();
    send(abc_blk, 1'b1, 1'b1, 1'b0, 1'b1, ABC_DIG);
    wait_idle();

    // Two-block message: only the second block produces a digest.
    send(rfc_blk(0), 1'b1, 1'b0, 1'b0, 1'b1, '0);
    send(rfc_blk(1), 1'b0, 1'b1, 1'b0, 1'b1, RFC_DIG);
    wait_idle();

    // Back-to-back with in_valid held; the empty message must restart from the IV.
    send(abc_blk, 1'b1, 1'b1, 1'b1, 1'b1, ABC_DIG);
    a1 = last_acc;
    send(empty_blk, 1'b1, 1'b1, 1'b0, 1'b1, EMPTY_DIG);
    check("b2b_accept_gap", 128'(last_acc - a1), 128'(66));
    wait_idle();

    // Junk on the input side while busy must neither be accepted nor disturb the digest.
    send(abc_blk, 1'b1, 1'b1, 1'b0, 1'b1, ABC_DIG);
    for (int k = 0; k < 30; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_first = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      in_block = {16{$urandom}};
      @(posedge clk); #1;
      check($sformatf("busy_ignores_input_%0d", k), 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    wait_idle();

    // Abort at step 20, then "abc" with in_first=0 must chain from the IV.
    send(abc_blk, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", 128'(in_ready), 128'(1));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_out_digest", out_digest, 128'(0));
    rst = 1'b0;
    send(abc_blk, 1'b0, 1'b1, 1'b0, 1'b1, ABC_DIG);
    wait_idle();

    // Wider unroll factors: "abc" with latency 64/UNROLL + 1 edges after accept.
    for (int j = 0; j < 4; j++) begin
      int n;
      int a;
      in_block = abc_blk;
      check($sformatf("u%0d_ready", 2 << j), 128'(xr[j]), 128'(1));
      xv[j] = 1'b1;
      @(posedge clk); #1;
      a = cyc;
      xv[j] = 1'b0;
      check($sformatf("u%0d_busy", 2 << j), 128'(xb[j]), 128'(1));
      n = 0;
      while (xo[j] !== 1'b1 && n < 80) begin
        @(posedge clk); #1;
        n++;
      end
      check($sformatf("u%0d_latency", 2 << j), 128'(cyc - a), 128'(64 / (2 << j) + 1));
      check($sformatf("u%0d_digest", 2 << j), xd[j], ABC_DIG);
      @(posedge clk); #1;
      check($sformatf("u%0d_pulse_end", 2 << j), 128'(xo[j]), 128'(0));
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
